// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one RAM port between two requesters.
//
// Device 0 is instruction fetch, device 1 is the load/store data path. Whole
// transactions are serialised: a winner is picked in IDLE, its request is
// registered onto the RAM port, and the arbiter stays BUSY until the RAM
// acknowledges (or the watchdog gives up). Every transaction is followed by
// at least one IDLE cycle.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> ties go to the device that did not
//                                        complete the previous transaction
//                           undefined -> fixed priority, device 1 wins ties
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   device_N_mem_en/addr/di/we request from device N (held until acked)
//   device_N_do_ack            one-cycle completion pulse to device N
//   mem_do                     read data (valid with a device ack)
//   ram_mem_en/addr/di/we      registered request to the RAM controller
//   ram_burst_en               always 0
//   ram_do_ack, ram_do         RAM completion and read data
//   grant                      one-hot current owner, 00 when idle
//   timeout_err                one-cycle pulse when the watchdog aborts
//
// States:
//   IDLE | no transaction outstanding; arbitrate on any request
//   BUSY | RAM request issued; waiting for ram_do_ack or watchdog expiry

module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              device_0_mem_en,
    input  logic [ADDR_W-1:0] device_0_mem_addr,
    input  logic [DATA_W-1:0] device_0_mem_di,
    input  logic              device_0_mem_we,
    output logic              device_0_do_ack,

    input  logic              device_1_mem_en,
    input  logic [ADDR_W-1:0] device_1_mem_addr,
    input  logic [DATA_W-1:0] device_1_mem_di,
    input  logic              device_1_mem_we,
    output logic              device_1_do_ack,

    output logic [DATA_W-1:0] mem_do,

    output logic              ram_mem_en,
    output logic [ADDR_W-1:0] ram_mem_addr,
    output logic [DATA_W-1:0] ram_mem_di,
    output logic              ram_mem_we,
    output logic              ram_burst_en,
    input  logic              ram_do_ack,
    input  logic [DATA_W-1:0] ram_do,

    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(ACK_TIMEOUT);
    localparam bit          WD_EN       = (ACK_TIMEOUT != 0);

    state_t              state, state_nxt;
    logic [15:0]         wd_count, wd_count_nxt;
    logic                last_grant, last_grant_nxt;   // 1 = device 1
    logic [1:0]          grant_nxt;
    logic                ram_mem_en_nxt;
    logic [ADDR_W-1:0]   ram_mem_addr_nxt;
    logic [DATA_W-1:0]   ram_mem_di_nxt;
    logic                ram_mem_we_nxt;
    logic                timeout_err_nxt;
    logic                any_req;
    logic                pick_dev1;
    logic                ack_ok;
    logic                wd_expire;

    assign ram_burst_en = 1'b0;
    assign mem_do       = ram_do;
    assign any_req      = device_0_mem_en | device_1_mem_en;

    // Acks are only forwarded in BUSY; a reset in the ack cycle discards it.
    assign ack_ok          = (state == BUSY) && ram_do_ack && !reset;
    assign device_0_do_ack = ack_ok && grant[0];
    assign device_1_do_ack = ack_ok && grant[1];

    // Fires in the last permitted BUSY cycle so the abort lands after exactly
    // ACK_TIMEOUT cycles without an ack.
    assign wd_expire = WD_EN && ((wd_count + 16'd1) == TIMEOUT_CNT);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        if (device_0_mem_en && device_1_mem_en) begin
            pick_dev1 = !last_grant;
        end else begin
            pick_dev1 = device_1_mem_en;
        end
    end
`else
    assign pick_dev1 = device_1_mem_en;
`endif

    always_comb begin
        state_nxt        = state;
        wd_count_nxt     = wd_count;
        last_grant_nxt   = last_grant;
        grant_nxt        = grant;
        ram_mem_en_nxt   = ram_mem_en;
        ram_mem_addr_nxt = ram_mem_addr;
        ram_mem_di_nxt   = ram_mem_di;
        ram_mem_we_nxt   = ram_mem_we;
        timeout_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt        = BUSY;
                    ram_mem_en_nxt   = 1'b1;
                    wd_count_nxt     = 16'd0;
                    grant_nxt        = pick_dev1 ? 2'b10 : 2'b01;
                    ram_mem_addr_nxt = pick_dev1 ? device_1_mem_addr : device_0_mem_addr;
                    ram_mem_di_nxt   = pick_dev1 ? device_1_mem_di   : device_0_mem_di;
                    ram_mem_we_nxt   = pick_dev1 ? device_1_mem_we   : device_0_mem_we;
                end
            end
            BUSY: begin
                if (ram_do_ack) begin
                    // Ack takes precedence over a simultaneous watchdog expiry.
                    state_nxt      = IDLE;
                    ram_mem_en_nxt = 1'b0;
                    grant_nxt      = 2'b00;
                    last_grant_nxt = grant[1];
                end else if (wd_expire) begin
                    state_nxt       = IDLE;
                    ram_mem_en_nxt  = 1'b0;
                    grant_nxt       = 2'b00;
                    timeout_err_nxt = 1'b1;
                end else begin
                    wd_count_nxt = wd_count + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wd_count     <= 16'd0;
            last_grant   <= 1'b1;
            grant        <= 2'b00;
            ram_mem_en   <= 1'b0;
            ram_mem_addr <= '0;
            ram_mem_di   <= '0;
            ram_mem_we   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            wd_count     <= wd_count_nxt;
            last_grant   <= last_grant_nxt;
            grant        <= grant_nxt;
            ram_mem_en   <= ram_mem_en_nxt;
            ram_mem_addr <= ram_mem_addr_nxt;
            ram_mem_di   <= ram_mem_di_nxt;
            ram_mem_we   <= ram_mem_we_nxt;
            timeout_err  <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: table of request patterns driven through
// per-device request drivers and a RAM model, with a scoreboard of expected
// completions, plus hand-written reset, stray-ack, watchdog and
// back-to-back arbitration sequences.

module tb_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] di;
        logic        we;
    } req_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] di;
        logic        we;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          r0;
        logic [31:0] a0;
        bit          we0;
        bit          r1;
        logic [31:0] a1;
        bit          we1;
        int          lat;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        en [2];
    logic [31:0] addr [2];
    logic [31:0] di [2];
    logic        we [2];
    logic        dev0_ack, dev1_ack;
    logic [31:0] mem_do;
    logic        ram_mem_en, ram_mem_we, ram_burst_en;
    logic [31:0] ram_mem_addr, ram_mem_di;
    logic        ram_do_ack;
    logic [31:0] ram_do;
    logic [1:0]  grant;
    logic        timeout_err;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(8)) dut (
        .clk               (clk),
        .reset             (reset),
        .device_0_mem_en   (en[0]),
        .device_0_mem_addr (addr[0]),
        .device_0_mem_di   (di[0]),
        .device_0_mem_we   (we[0]),
        .device_0_do_ack   (dev0_ack),
        .device_1_mem_en   (en[1]),
        .device_1_mem_addr (addr[1]),
        .device_1_mem_di   (di[1]),
        .device_1_mem_we   (we[1]),
        .device_1_do_ack   (dev1_ack),
        .mem_do            (mem_do),
        .ram_mem_en        (ram_mem_en),
        .ram_mem_addr      (ram_mem_addr),
        .ram_mem_di        (ram_mem_di),
        .ram_mem_we        (ram_mem_we),
        .ram_burst_en      (ram_burst_en),
        .ram_do_ack        (ram_do_ack),
        .ram_do            (ram_do),
        .grant             (grant),
        .timeout_err       (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_on = 1'b0;

    req_t req_q0[$];
    req_t req_q1[$];
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    bit   busy [2];
    bit   ack_seen [2];
    bit   abort [2];
    bit   prev_ack [2];
    int   ack_cnt [2];
    int   present_cyc [2];

    bit   ram_auto = 1'b0;
    int   ram_lat = 3;
    int   ram_cnt = 0;

    int   owner = -1;
    bit   prev_en = 1'b0;
    bit   seen_fall = 1'b0;
    int   low_cnt = 0;
    int   en_high_cnt = 0;
    int   tmo_cnt = 0;
    int   tmo_len = 0;
    int   order_log[$];
    int   gap_log[$];
    int   lat_log[$];
    int   exp_order[$];
    bit   model_last = 1'b1;

    function automatic logic [31:0] ram_data(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic handle_ack(input int n, input logic a);
        exp_t e;
        if (a) begin
            ack_cnt[n]++;
            checks++;
            if (prev_ack[n]) begin
                errors++;
                $display("FAIL ack_width dev%0d: ack high two cycles in a row", n);
            end
            if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack dev%0d: got ack, expected none (cycle %0d)", n, cyc);
            end else begin
                e = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("mem_do dev%0d", n), mem_do, e.data);
                check($sformatf("ram_addr dev%0d", n), ram_mem_addr, e.addr);
                check($sformatf("ram_di dev%0d", n), ram_mem_di, e.di);
                check($sformatf("ram_we dev%0d", n), 32'(ram_mem_we), 32'(e.we));
            end
            ack_seen[n] = 1'b1;
        end
        prev_ack[n] = a;
    endtask

    // Sampled at the falling edge.
    task automatic monitor();
        logic a0, a1;
        a0 = dev0_ack;
        a1 = dev1_ack;
        check("ram_burst_en", 32'(ram_burst_en), 32'd0);
        if (ram_mem_en)
            check("grant_onehot", 32'(grant == 2'b01 || grant == 2'b10), 32'd1);
        else
            check("grant_idle", 32'(grant), 32'd0);
        handle_ack(0, a0);
        handle_ack(1, a1);
        if (timeout_err) begin
            tmo_cnt++;
            tmo_len = en_high_cnt;
            check("tmo_en_low", 32'(ram_mem_en), 32'd0);
        end
        if (ram_mem_en && !prev_en) begin
            owner = grant[1] ? 1 : 0;
            order_log.push_back(owner);
            if (seen_fall) gap_log.push_back(low_cnt);
            lat_log.push_back(cyc - present_cyc[owner]);
            en_high_cnt = 0;
        end
        if (ram_mem_en) begin
            en_high_cnt++;
        end else begin
            if (prev_en) begin
                seen_fall = 1'b1;
                low_cnt = 0;
            end
            low_cnt++;
        end
        prev_en = ram_mem_en;
    endtask

    // Applied just after the rising edge: device drivers and the RAM model.
    task automatic drive();
        req_t r;
        exp_t e;
        for (int n = 0; n < 2; n++) begin
            if (busy[n] && (ack_seen[n] || abort[n] || (timeout_err === 1'b1 && owner == n))) begin
                if (!ack_seen[n] && !abort[n]) begin
                    if (n == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
                busy[n] = 1'b0;
                abort[n] = 1'b0;
            end
            ack_seen[n] = 1'b0;
            if (!busy[n] && ((n == 0 && req_q0.size() > 0) || (n == 1 && req_q1.size() > 0))) begin
                r = (n == 0) ? req_q0.pop_front() : req_q1.pop_front();
                en[n] = 1'b1;
                addr[n] = r.addr;
                di[n] = r.di;
                we[n] = r.we;
                e.addr = r.addr;
                e.di = r.di;
                e.we = r.we;
                e.data = ram_data(r.addr);
                if (n == 0) exp_q0.push_back(e);
                else        exp_q1.push_back(e);
                present_cyc[n] = cyc;
                busy[n] = 1'b1;
            end else if (!busy[n]) begin
                en[n] = 1'b0;
            end
        end
        ram_do_ack = 1'b0;
        if (ram_auto && ram_mem_en === 1'b1) begin
            if (ram_cnt == ram_lat) begin
                ram_do_ack = 1'b1;
                ram_do = ram_data(ram_mem_addr);
                ram_cnt = 0;
            end else begin
                ram_cnt++;
            end
        end else begin
            ram_cnt = 0;
            ram_do = 32'h0BAD_0000 | 32'(cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (mon_on) monitor();
        @(posedge clk);
        cyc++;
        #1;
        drive();
    endtask

    task automatic push_req(input int n, input logic [31:0] a, input logic w);
        req_t r;
        r.addr = a;
        r.di = a ^ 32'hFFFF_0000;
        r.we = w;
        if (n == 0) req_q0.push_back(r);
        else        req_q1.push_back(r);
    endtask

    task automatic clear_logs();
        order_log.delete();
        gap_log.delete();
        lat_log.delete();
        seen_fall = 1'b0;
    endtask

    task automatic run_until_idle(input string name, input int max_cyc);
        int n = 0;
        while ((req_q0.size() > 0 || req_q1.size() > 0 || busy[0] || busy[1]) && n < max_cyc) begin
            tick();
            n++;
        end
        check({name, "_done_in_time"}, 32'(n < max_cyc), 32'd1);
        tick();
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_last = 1'b1;
    endtask

    vec_t vecs [5];

    initial begin
        int n;
        int t0;
        int a0_cnt, a1_cnt;
        bit first;

        vecs[0] = '{r0: 1, a0: 32'h100, we0: 0, r1: 0, a1: 32'h0,  we1: 0, lat: 3};
        vecs[1] = '{r0: 0, a0: 32'h0,   we0: 0, r1: 1, a1: 32'h200, we1: 1, lat: 2};
        vecs[2] = '{r0: 1, a0: 32'h10,  we0: 0, r1: 1, a1: 32'h20,  we1: 0, lat: 3};
        vecs[3] = '{r0: 1, a0: 32'h30,  we0: 1, r1: 1, a1: 32'h40,  we1: 0, lat: 0};
        vecs[4] = '{r0: 1, a0: 32'h50,  we0: 1, r1: 0, a1: 32'h0,   we1: 0, lat: 7};

        reset = 1'b1;
        ram_do_ack = 1'b0;
        ram_do = 32'h0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0;
            addr[i] = 32'h0;
            di[i] = 32'h0;
            we[i] = 1'b0;
        end

        do_reset();
        reset = 1'b1;
        check("rst_ram_en", 32'(ram_mem_en), 32'd0);
        check("rst_ram_addr", ram_mem_addr, 32'd0);
        check("rst_ram_di", ram_mem_di, 32'd0);
        check("rst_ram_we", 32'(ram_mem_we), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        prev_en = 1'b0;
        mon_on = 1'b1;

        // Table-driven request patterns.
        ram_auto = 1'b1;
        for (int v = 0; v < 5; v++) begin
            clear_logs();
            exp_order.delete();
            ram_lat = vecs[v].lat;
            if (vecs[v].r0) push_req(0, vecs[v].a0, vecs[v].we0);
            if (vecs[v].r1) push_req(1, vecs[v].a1, vecs[v].we1);
            if (vecs[v].r0 && vecs[v].r1) begin
                first = RR ? !model_last : 1'b1;
                exp_order.push_back(int'(first));
                exp_order.push_back(int'(!first));
            end else begin
                exp_order.push_back(vecs[v].r1 ? 1 : 0);
            end
            run_until_idle($sformatf("vec%0d", v), 200);
            check($sformatf("vec%0d_txn_count", v), order_log.size(), exp_order.size());
            for (int i = 0; i < exp_order.size() && i < order_log.size(); i++)
                check($sformatf("vec%0d_order%0d", v, i), order_log[i], exp_order[i]);
            if (lat_log.size() > 0)
                check($sformatf("vec%0d_req_latency", v), lat_log[0], 32'd1);
            if (exp_order.size() == 2 && gap_log.size() > 0)
                check($sformatf("vec%0d_bubble", v), gap_log[0], 32'd1);
            check($sformatf("vec%0d_scoreboard0", v), exp_q0.size(), 32'd0);
            check($sformatf("vec%0d_scoreboard1", v), exp_q1.size(), 32'd0);
            model_last = exp_order[exp_order.size() - 1] != 0;
        end
        check("no_timeout_in_vectors", tmo_cnt, 32'd0);

        // Reset in the second BUSY cycle with an ack arriving in that cycle.
        ram_auto = 1'b0;
        a0_cnt = ack_cnt[0];
        push_req(0, 32'h300, 1'b0);
        n = 0;
        while (ram_mem_en !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("rst_seq_started", 32'(ram_mem_en), 32'd1);
        tick();
        reset = 1'b1;
        ram_do_ack = 1'b1;
        ram_do = 32'h1234_5678;
        abort[0] = 1'b1;
        void'(exp_q0.pop_front());
        #2;
        check("rst_ack_not_forwarded", 32'(dev0_ack), 32'd0);
        tick();
        check("rst_mid_ram_en", 32'(ram_mem_en), 32'd0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        model_last = 1'b1;
        tick();
        tick();
        check("rst_no_reissue", 32'(ram_mem_en), 32'd0);
        check("rst_ack_count", ack_cnt[0], a0_cnt);

        // Stray ack while IDLE.
        ram_do_ack = 1'b1;
        #2;
        check("stray_ack_dev0", 32'(dev0_ack), 32'd0);
        check("stray_ack_dev1", 32'(dev1_ack), 32'd0);
        tick();
        check("stray_ram_en", 32'(ram_mem_en), 32'd0);
        check("stray_grant", 32'(grant), 32'd0);

        // Watchdog: device 1 write, RAM never acks.
        a0_cnt = ack_cnt[0];
        a1_cnt = ack_cnt[1];
        t0 = tmo_cnt;
        push_req(1, 32'h400, 1'b1);
        n = 0;
        while (tmo_cnt == t0 && n < 50) begin
            tick();
            n++;
        end
        check("wd_fired", tmo_cnt, t0 + 1);
        check("wd_busy_cycles", tmo_len, 32'd8);
        check("wd_no_ack0", ack_cnt[0], a0_cnt);
        check("wd_no_ack1", ack_cnt[1], a1_cnt);
        tick();
        check("wd_pulse_len", 32'(timeout_err), 32'd0);
        check("wd_ram_en_low", 32'(ram_mem_en), 32'd0);
        ram_do_ack = 1'b1;
        #2;
        check("wd_late_ack0", 32'(dev0_ack), 32'd0);
        check("wd_late_ack1", 32'(dev1_ack), 32'd0);
        tick();
        check("wd_late_ram_en", 32'(ram_mem_en), 32'd0);
        check("wd_late_ack_count", ack_cnt[1], a1_cnt);

        // Both devices keep requesting for four transactions.
        do_reset();
        clear_logs();
        ram_auto = 1'b1;
        ram_lat = 1;
        push_req(0, 32'h600, 1'b0);
        push_req(0, 32'h604, 1'b1);
        push_req(1, 32'h700, 1'b0);
        push_req(1, 32'h704, 1'b1);
        exp_order.delete();
        if (RR) begin
            exp_order.push_back(0);
            exp_order.push_back(1);
            exp_order.push_back(0);
            exp_order.push_back(1);
        end else begin
            exp_order.push_back(1);
            exp_order.push_back(1);
            exp_order.push_back(0);
            exp_order.push_back(0);
        end
        run_until_idle("b2b", 200);
        check("b2b_txn_count", order_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < order_log.size(); i++)
            check($sformatf("b2b_order%0d", i), order_log[i], exp_order[i]);
        check("b2b_gap_count", gap_log.size(), 32'd3);
        for (int i = 0; i < gap_log.size(); i++)
            check($sformatf("b2b_bubble%0d", i), gap_log[i], 32'd1);
        check("b2b_scoreboard0", exp_q0.size(), 32'd0);
        check("b2b_scoreboard1", exp_q1.size(), 32'd0);
        check("total_timeouts", tmo_cnt, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between two requesters: device 0 (instruction fetch) and device 1 (load/store data path).
- Sits between the pipeline's memory-side ports and the RAM controller, and serialises whole transactions.
- Routes the RAM acknowledge and read data back to the granted requester only.
- Includes an acknowledge watchdog so a lost RAM ack cannot hang the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- ACK_TIMEOUT, 1023, cycles to wait for ram_do_ack before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- device_0_mem_en  in  1  fetch request; held high until acked.
- device_0_mem_addr  in  ADDR_W  fetch address; stable while en is high.
- device_0_mem_di  in  DATA_W  fetch write data (unused by fetch, still forwarded).
- device_0_mem_we  in  1  fetch write enable.
- device_0_do_ack  out  1  one-cycle completion pulse to device 0.
- device_1_mem_en, device_1_mem_addr, device_1_mem_di, device_1_mem_we  in  as device 0  data-port request.
- device_1_do_ack  out  1  one-cycle completion pulse to device 1.
- mem_do  out  DATA_W  read data, shared; valid only with a device ack.
- ram_mem_en  out  1  RAM request, registered.
- ram_mem_addr  out  ADDR_W  registered address.
- ram_mem_di  out  DATA_W  registered write data.
- ram_mem_we  out  1  registered write enable.
- ram_burst_en  out  1  tied 0; no bursts.
- ram_do_ack  in  1  RAM completion.
- ram_do  in  DATA_W  RAM read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- States: IDLE and BUSY.
- Reset: state=IDLE; ram_mem_en=0; ram_mem_addr=0; ram_mem_di=0; ram_mem_we=0; grant=00; timeout_err=0; watchdog count=0; last_grant=device 1.
- IDLE, no device_N_mem_en high: stay in IDLE, all outputs idle.
- IDLE, any device_N_mem_en high:
  - Select a winner.
  - Register the winner's addr/di/we onto ram_mem_*.
  - ram_mem_en=1 and grant set from the next cycle; go to BUSY.
  - Request-to-RAM latency is 1 cycle.
- Arbitration (macro absent): fixed priority, device 1 over device 0.
- BUSY: ram_* outputs hold stable; the requester inputs are not re-sampled.
- BUSY with ram_do_ack=1:
  - device_N_do_ack = ram_do_ack AND grant[N], combinational, 0-cycle.
  - mem_do = ram_do.
  - Next edge: ram_mem_en=0, grant=00, last_grant=N, state IDLE.
- Back-to-back transactions always have one IDLE bubble cycle. The acked requester must drop en, or present its next request, in the cycle after its ack.
- ram_do_ack while IDLE: ignored; no device ack is generated.
- Watchdog (ACK_TIMEOUT>0):
  - 16-bit count clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching ACK_TIMEOUT: pulse timeout_err for one cycle, drop ram_mem_en, go to IDLE, and issue no device ack.
  - Ack and timeout in the same cycle: the ack wins and timeout_err stays 0.
- Requester drops en while granted: illegal. The arbiter completes the transaction regardless, and the ack is still pulsed.
- reset mid-BUSY: returns to the reset state next edge; a pending ram_do_ack is discarded.
- mem_do outside an ack cycle: don't-care, but it must equal ram_do (no extra mux state).

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - On a tie in IDLE, grant the device not equal to last_grant.
  - last_grant resets to device 1, so device 0 wins the first tie.
  - A lone requester always wins.
- Undefined: fixed priority as above; last_grant is still maintained but does not affect selection.

Test Plan:
- Single fetch: device_0 en, addr=0x100, RAM acks 3 cycles after ram_mem_en → ram_mem_en rises 1 cycle after request, ram_mem_addr=0x100, device_0_do_ack pulses 1 cycle with mem_do=0xDEADBEEF, grant returns to 00.
- Contention without the macro: both en high in the same cycle, addr0=0x10, addr1=0x20 → first RAM access is 0x20 (device 1); after its ack plus the 1 bubble cycle, 0x10 is issued; device_1_do_ack precedes device_0_do_ack.
- Contention with MEM_ARB_ROUND_ROBIN_EN, both held high for 4 transactions → grant order 0,1,0,1; each transaction separated by exactly 1 IDLE cycle.
- Watchdog: ACK_TIMEOUT=8, device_1 write, no ram_do_ack → timeout_err pulses after 8 BUSY cycles, ram_mem_en falls, neither device ack pulses; a late ram_do_ack in IDLE is ignored.
- Reset mid-transaction: assert reset in the 2nd BUSY cycle → next edge ram_mem_en=0 and grant=00; an ack arriving the same cycle is not forwarded.
- Stray ack: ram_do_ack=1 while IDLE → device_0_do_ack=device_1_do_ack=0 and the state is unchanged.
